// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the two-manager OBI SRAM arbiter.
// Latency: n/a (types only); backpressure: n/a.
package obi_arb_pkg;

    typedef logic mgr_id_t;

    localparam int NumMgr       = 2;
    localparam int FifoDepthDef = 2;

endpackage

// File: rtl/obi_sram_arb_if.sv
// Bus bundle between two OBI managers, the arbiter and one SRAM subordinate.
// Latency: n/a (wires only); backpressure: gnt from arbiter, s_gnt from subordinate.
interface obi_sram_arb_if #(
    parameter int AddrW = 32,
    parameter int DataW = 32
);
    import obi_arb_pkg::*;

    localparam int BeW = DataW / 8;

    logic [NumMgr-1:0]                m_req_i;
    logic [NumMgr-1:0]                m_gnt_o;
    logic [NumMgr-1:0][AddrW-1:0]     m_addr_i;
    logic [NumMgr-1:0]                m_we_i;
    logic [NumMgr-1:0][BeW-1:0]       m_be_i;
    logic [NumMgr-1:0][DataW-1:0]     m_wdata_i;
    logic [NumMgr-1:0]                m_rvalid_o;
    logic [DataW-1:0]                 m_rdata_o;

    logic                             s_req_o;
    logic                             s_we_o;
    logic [BeW-1:0]                   s_be_o;
    logic [AddrW-1:0]                 s_addr_o;
    logic [DataW-1:0]                 s_wdata_o;
    logic                             s_gnt_i;
    logic                             s_rvalid_i;
    logic [DataW-1:0]                 s_rdata_i;

    // master: the arbiter's view; slave: the surrounding managers and SRAM
    modport master (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        input  s_gnt_i, s_rvalid_i, s_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o,
        output s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o
    );

    modport slave (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        output s_gnt_i, s_rvalid_i, s_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o,
        input  s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o
    );

endinterface

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of granted manager IDs used to route SRAM responses back.
// Latency: head valid the cycle after push; backpressure: push ignored when full, pop ignored when empty.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int Depth = FifoDepthDef
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push,
    input  mgr_id_t push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output mgr_id_t head
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    mgr_id_t         mem_q [Depth];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt_q == CntW'(Depth));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Depth is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= push_id;
    end

endmodule

// File: rtl/obi_sram_arb.sv
// Round-robin arbiter sharing one OBI SRAM port between instruction (0) and data (1) managers.
// Latency: grant combinational, response zero added latency; backpressure: no grant while s_gnt low or ID FIFO full.
module obi_sram_arb
    import obi_arb_pkg::*;
#(
    parameter int AddrW     = 32,
    parameter int DataW     = 32,
    parameter int FifoDepth = FifoDepthDef
) (
    input  logic           clk_i,
    input  logic           rst_i,
    obi_sram_arb_if.master bus,
    output logic           err_o
);

    localparam int BeW = DataW / 8;

    mgr_id_t          last_q;
    mgr_id_t          winner;
    mgr_id_t          head_id;
    logic             any_req;
    logic             s_req;
    logic             xfer;
    logic             fifo_full;
    logic             fifo_empty;
    logic             resp_ok;
    logic [AddrW-1:0] addr_mux;
    logic [DataW-1:0] wdata_mux;
    logic [BeW-1:0]   be_mux;
    logic             we_mux;

    // Under contention the manager not served last wins
    always_comb begin
        winner = 1'b0;
        if (bus.m_req_i[1] && bus.m_req_i[0]) begin
            winner = ~last_q;
        end else if (bus.m_req_i[1]) begin
            winner = 1'b1;
        end
    end

    assign any_req = |bus.m_req_i;
    assign s_req   = any_req && !fifo_full && !rst_i;
    assign xfer    = s_req && bus.s_gnt_i;

    always_comb begin
        bus.m_gnt_o = '0;
        if (xfer) bus.m_gnt_o[winner] = 1'b1;
    end

    assign addr_mux  = bus.m_addr_i[winner];
    assign wdata_mux = bus.m_wdata_i[winner];
    assign be_mux    = bus.m_be_i[winner];
    assign we_mux    = bus.m_we_i[winner];

    assign bus.s_req_o   = s_req;
    assign bus.s_addr_o  = addr_mux;
    assign bus.s_wdata_o = wdata_mux;
    assign bus.s_be_o    = be_mux;
    assign bus.s_we_o    = we_mux;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (xfer) begin
            last_q <= winner;
        end
    end

    obi_arb_id_fifo #(
        .Depth (FifoDepth)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (xfer),
        .push_id (winner),
        .pop     (resp_ok),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head_id)
    );

    // A response with nothing outstanding is flagged, not routed
    assign resp_ok = bus.s_rvalid_i && !fifo_empty && !rst_i;
    assign err_o   = bus.s_rvalid_i && fifo_empty && !rst_i;

    always_comb begin
        bus.m_rvalid_o = '0;
        if (resp_ok) bus.m_rvalid_o[head_id] = 1'b1;
    end

    assign bus.m_rdata_o = bus.s_rdata_i;

endmodule

// File: doc/obi_sram_arb.md
OBI_SRAM_ARB -- requirements
Module: obi_sram_arb

Interface
REQ-001 SHALL have parameter AddrW, default 32, meaning manager and subordinate address width.
REQ-002 SHALL have parameter DataW, default 32, meaning data width; BeW = DataW/8.
REQ-003 SHALL have parameter FifoDepth, default 2, meaning max outstanding transactions; power of two, at least 2.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 m_req_i[1:0]  in  2  per-manager request; index 0 = instruction port, 1 = data port.
REQ-007 m_gnt_o[1:0]  out  2  per-manager grant.
REQ-008 m_addr_i[1:0], m_we_i[1:0], m_be_i[1:0], m_wdata_i[1:0]  in  AddrW/1/BeW/DataW each  per-manager request payload.
REQ-009 m_rvalid_o[1:0]  out  2  per-manager response valid; m_rdata_o  out  DataW  shared read data.
REQ-010 s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o  out  1/1/BeW/AddrW/DataW  request to the SRAM subordinate.
REQ-011 s_gnt_i  in  1  subordinate accept; s_rvalid_i  in  1  response valid; s_rdata_i  in  DataW.
REQ-012 err_o  out  1  one-cycle pulse on an unexpected response.

Function
REQ-013 Handshake: transfer occurs on a manager in a cycle where m_req_i and m_gnt_o are both high; one transfer per cycle total.
REQ-014 Arbitration: round-robin; single requester wins immediately; on contention the manager not granted last wins; the last-granted pointer updates only on a completed transfer.
REQ-015 Grant is combinational: m_gnt_o[w] = winner w AND s_gnt_i AND NOT fifo_full; the non-winner gnt is low.
REQ-016 s_req_o is high iff any m_req_i is high and fifo is not full; s_* payload muxes from the current winner (manager 0 when idle).
REQ-017 Each completed transfer pushes the winner ID into an in-order ID FIFO of depth FifoDepth.
REQ-018 s_rvalid_i pops the FIFO head; m_rvalid_o[head] = s_rvalid_i in the same cycle (zero added latency); m_rdata_o = s_rdata_i passthrough.
REQ-019 Push and pop in the same cycle leave the count unchanged; a full FIFO with a simultaneous pop still blocks the grant that cycle.
REQ-020 s_rvalid_i with an empty FIFO: no m_rvalid_o asserted, count unchanged, err_o pulses high for that cycle.
REQ-021 Count and pointers wrap modulo FifoDepth; the count never exceeds FifoDepth.
REQ-022 With a one-cycle SRAM latency, back-to-back single-manager requests sustain one transfer per cycle.

Reset
REQ-023 In a cycle with rst_i high, all state clears at the edge: FIFO empty, read/write pointers 0, last-granted = 1 (manager 0 wins the first contention), err_o 0.
REQ-024 During reset, m_gnt_o, m_rvalid_o, s_req_o and err_o SHALL be 0.
REQ-025 Reset mid-transaction discards outstanding IDs; a later s_rvalid_i with an empty FIFO raises err_o per REQ-020.

Structure
REQ-026 Package obi_arb_pkg SHALL hold the mgr_id_t typedef (1 bit), NumMgr = 2, and the default FifoDepth constant.
REQ-027 ID FIFO SHALL be a sub-module obi_arb_id_fifo (push, pop, full, empty, head); arbitration and muxing stay in the top level.

Verification
REQ-028 Only m0 requests 4 reads back-to-back, SRAM latency 1 -> 4 grants in 4 consecutive cycles; m_rvalid_o[0] on cycles 2-5; m_rvalid_o[1] never set.
REQ-029 Both managers request continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; rvalids follow the same order.
REQ-030 s_gnt_i held low 3 cycles with m1 requesting -> no grant and no FIFO push; grant on the first cycle s_gnt_i is high.
REQ-031 Subordinate withholds s_rvalid_i after 2 accepts -> third request is not granted (fifo_full); on the pop cycle still no grant; grant the next cycle.
REQ-032 s_rvalid_i pulsed with an empty FIFO -> err_o high for exactly 1 cycle, no m_rvalid_o asserted.
REQ-033 rst_i asserted with 2 outstanding transactions -> FIFO empty after reset; two late s_rvalid_i -> two err_o pulses, no m_rvalid_o.
